// File: rtl/machine_timer_pkg.sv
// Shared definitions for the machine timer: register map, CTRL field layout,
// bus handshake state encoding and the compare register reset value.
package machine_timer_pkg;

    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] OFF_MTIME_LO = 5'h00;
    localparam logic [ADDR_W-1:0] OFF_MTIME_HI = 5'h04;
    localparam logic [ADDR_W-1:0] OFF_CMP_LO   = 5'h08;
    localparam logic [ADDR_W-1:0] OFF_CMP_HI   = 5'h0C;
    localparam logic [ADDR_W-1:0] OFF_MSIP     = 5'h10;
    localparam logic [ADDR_W-1:0] OFF_CTRL     = 5'h14;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_DIV_LSB = 8;

    localparam logic [63:0] CMP_RESET_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

    // One-hot so a corrupted state is easy to spot on a waveform.
    typedef enum logic [1:0] {
        BUS_IDLE = 2'b01,
        BUS_RESP = 2'b10
    } bus_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Divide-by-(DIV+1) tick generator for mtime; holds its count while disabled
// and restarts from zero whenever the control register is rewritten.
module timer_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_reg;

    assign tick = en && (cnt_reg == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr || tick) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/machine_timer.sv
// CLINT-style machine timer: 64-bit mtime/mtimecmp, msip and a control register
// behind a two-cycle req/ack bus, driving the timer and software interrupt lines.
module machine_timer
    import machine_timer_pkg::*;
#(
    parameter int          DIV_W     = 8,
    parameter logic [63:0] CMP_RESET = CMP_RESET_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              ack_o,
    output logic              err_o,
    output logic              timer_irq_o,
    output logic              sw_irq_o
);

    bus_state_t       state_reg, state_next;
    logic [63:0]      mtime_reg;
    logic [63:0]      mtimecmp_reg;
    logic             msip_reg;
    logic             en_reg;
    logic [DIV_W-1:0] div_reg;
    logic [31:0]      hi_shadow_reg;
    logic [31:0]      rdata_reg;
    logic             err_reg;
    logic             timer_irq_reg;
    logic             sw_irq_reg;

    logic        access, wr, rd, tick;
    logic        addr_bad;
    logic [31:0] read_data;
    logic [31:0] ctrl_value;

    assign access = (state_reg == BUS_IDLE) && req_i;
    assign wr     = access && we_i;
    assign rd     = access && !we_i;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            BUS_IDLE: if (req_i) state_next = BUS_RESP;
            BUS_RESP: state_next = BUS_IDLE;
            default:  state_next = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= BUS_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    timer_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .en    (en_reg),
        .clr   (wr && (addr_i == OFF_CTRL)),
        .div   (div_reg),
        .tick  (tick)
    );

    always_comb begin
        ctrl_value = '0;
        ctrl_value[CTRL_EN_BIT] = en_reg;
        ctrl_value[CTRL_DIV_LSB +: DIV_W] = div_reg;
    end

    // The HI offset returns the half captured by the last LO read, so LO-then-HI is atomic.
    always_comb begin
        read_data = '0;
        addr_bad  = 1'b0;
        case (addr_i)
            OFF_MTIME_LO: read_data = mtime_reg[31:0];
            OFF_MTIME_HI: read_data = hi_shadow_reg;
            OFF_CMP_LO:   read_data = mtimecmp_reg[31:0];
            OFF_CMP_HI:   read_data = mtimecmp_reg[63:32];
            OFF_MSIP:     read_data = {31'b0, msip_reg};
            OFF_CTRL:     read_data = ctrl_value;
            default:      addr_bad  = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_reg     <= '0;
            err_reg       <= 1'b0;
            hi_shadow_reg <= '0;
        end else begin
            rdata_reg <= rd ? read_data : 32'b0;
            err_reg   <= access && addr_bad;
            if (rd && (addr_i == OFF_MTIME_LO)) begin
                hi_shadow_reg <= mtime_reg[63:32];
            end
        end
    end

    // A software write to either half swallows a coincident tick entirely.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mtime_reg <= '0;
        end else if (wr && (addr_i == OFF_MTIME_LO)) begin
            mtime_reg[31:0] <= wdata_i;
        end else if (wr && (addr_i == OFF_MTIME_HI)) begin
            mtime_reg[63:32] <= wdata_i;
        end else if (tick) begin
            mtime_reg <= mtime_reg + 64'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mtimecmp_reg <= CMP_RESET;
            msip_reg     <= 1'b0;
            en_reg       <= 1'b0;
            div_reg      <= '0;
        end else if (wr) begin
            case (addr_i)
                OFF_CMP_LO: mtimecmp_reg[31:0]  <= wdata_i;
                OFF_CMP_HI: mtimecmp_reg[63:32] <= wdata_i;
                OFF_MSIP:   msip_reg            <= wdata_i[0];
                OFF_CTRL: begin
                    en_reg  <= wdata_i[CTRL_EN_BIT];
                    div_reg <= wdata_i[CTRL_DIV_LSB +: DIV_W];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            timer_irq_reg <= 1'b0;
            sw_irq_reg    <= 1'b0;
        end else begin
            timer_irq_reg <= (mtime_reg >= mtimecmp_reg);
            sw_irq_reg    <= msip_reg;
        end
    end

    assign ack_o       = (state_reg == BUS_RESP);
    assign rdata_o     = rdata_reg;
    assign err_o       = err_reg;
    assign timer_irq_o = timer_irq_reg;
    assign sw_irq_o    = sw_irq_reg;

endmodule

// File: tb/tb_machine_timer.sv
// Directed plus randomized bus traffic against the machine timer, checked
// against a transaction-level model of the register map and tick rate.
module tb_machine_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack, err, timer_irq, sw_irq;

    int vectors = 0;
    int miscompares = 0;

    machine_timer dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_i       (req),
        .we_i        (we),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
        .ack_o       (ack),
        .err_o       (err),
        .timer_irq_o (timer_irq),
        .sw_irq_o    (sw_irq)
    );

    always #5 clk = ~clk;

    // Reference state: architectural registers plus "enabled cycles since CTRL write".
    logic [63:0]     m_mtime, m_cmp;
    logic [31:0]     m_shadow, m_rdata;
    bit              m_msip, m_en, m_irq, m_sw, m_busy, m_err;
    int unsigned     m_div;
    longint unsigned m_phase;

    function automatic void model_reset();
        m_mtime = '0; m_cmp = '1; m_shadow = '0; m_rdata = '0;
        m_msip = 0; m_en = 0; m_irq = 0; m_sw = 0; m_busy = 0; m_err = 0;
        m_div = 0; m_phase = 0;
    endfunction

    function automatic void model_edge();
        bit tick, acc, mapped, wrote_mtime, new_irq, new_sw;
        tick    = m_en && ((m_phase % longint'(m_div + 1)) == longint'(m_div));
        acc     = req && !m_busy;
        new_irq = (m_mtime >= m_cmp);
        new_sw  = m_msip;
        mapped  = addr inside {5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14};
        wrote_mtime = 0;
        m_rdata = '0;
        m_err   = acc && !mapped;
        if (m_en) m_phase++;
        if (acc && !we) begin
            case (addr)
                5'h00: begin m_rdata = m_mtime[31:0]; m_shadow = m_mtime[63:32]; end
                5'h04: m_rdata = m_shadow;
                5'h08: m_rdata = m_cmp[31:0];
                5'h0C: m_rdata = m_cmp[63:32];
                5'h10: m_rdata = {31'b0, m_msip};
                5'h14: m_rdata = {16'b0, 8'(m_div), 7'b0, m_en};
                default: m_rdata = '0;
            endcase
        end
        if (acc && we) begin
            case (addr)
                5'h00: begin m_mtime[31:0] = wdata; wrote_mtime = 1; end
                5'h04: begin m_mtime[63:32] = wdata; wrote_mtime = 1; end
                5'h08: m_cmp[31:0] = wdata;
                5'h0C: m_cmp[63:32] = wdata;
                5'h10: m_msip = wdata[0];
                5'h14: begin m_en = wdata[0]; m_div = wdata[15:8]; m_phase = 0; end
                default: ;
            endcase
        end
        if (tick && !wrote_mtime) m_mtime = m_mtime + 64'd1;
        m_busy = acc;
        m_irq  = new_irq;
        m_sw   = new_sw;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_edge();
        #1;
        check("timer_irq", {63'b0, timer_irq}, {63'b0, m_irq});
        check("sw_irq", {63'b0, sw_irq}, {63'b0, m_sw});
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    // Initiator holds req through the ack cycle; the DUT must ignore it there.
    task automatic bus(input bit w, input logic [4:0] a, input logic [31:0] d,
                       input string tag, output logic [31:0] rd_val, output logic er_val);
        req = 1'b1; we = w; addr = a; wdata = d;
        cycle();
        rd_val = rdata; er_val = err;
        check({tag, " ack"}, {63'b0, ack}, 64'd1);
        check({tag, " err"}, {63'b0, err}, {63'b0, m_err});
        if (!w) check({tag, " rdata"}, {32'b0, rdata}, {32'b0, m_rdata});
        cycle();
        check({tag, " ack_drop"}, {63'b0, ack}, 64'd0);
        req = 1'b0; we = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rv;
        logic        ev;
        logic [4:0]  rnd_addr [9];
        rnd_addr = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C, 5'h02};

        model_reset();
        idle(3);
        check("reset ack", {63'b0, ack}, 64'd0);
        check("reset err", {63'b0, err}, 64'd0);
        check("reset rdata", {32'b0, rdata}, 64'd0);
        rst_n = 1'b1;
        cycle();

        bus(0, 5'h14, 0, "rd_ctrl", rv, ev);   check("ctrl_reset", {32'b0, rv}, 64'd0);
        bus(0, 5'h00, 0, "rd_lo", rv, ev);     check("mtime_lo_reset", {32'b0, rv}, 64'd0);
        bus(0, 5'h0C, 0, "rd_cmphi", rv, ev);  check("cmp_hi_reset", {32'b0, rv}, 64'hFFFF_FFFF);

        // EN with DIV=3: one increment per four clocks.
        bus(1, 5'h14, 32'h0000_0301, "ctrl_div3", rv, ev);
        idle(40);
        bus(0, 5'h00, 0, "rd_div3", rv, ev);   check("div3_count", {32'b0, rv}, 64'd10);

        // 64-bit wrap: FFFF..FFFE plus two ticks freezes at zero.
        bus(1, 5'h14, 0, "ctrl_off", rv, ev);
        bus(1, 5'h04, 32'hFFFF_FFFF, "wr_hi", rv, ev);
        bus(1, 5'h00, 32'hFFFF_FFFE, "wr_lo", rv, ev);
        bus(1, 5'h14, 32'h1, "ctrl_div0", rv, ev);
        bus(1, 5'h14, 0, "ctrl_off", rv, ev);
        bus(0, 5'h00, 0, "rd_lo", rv, ev);     check("wrap_lo", {32'b0, rv}, 64'd0);
        bus(0, 5'h04, 0, "rd_hi", rv, ev);     check("wrap_hi", {32'b0, rv}, 64'd0);

        // LO->HI carry with DIV=1: exactly one tick before freezing.
        bus(1, 5'h00, 32'hFFFF_FFFF, "wr_lo", rv, ev);
        bus(1, 5'h14, 32'h0000_0101, "ctrl_div1", rv, ev);
        bus(1, 5'h14, 0, "ctrl_off", rv, ev);
        bus(0, 5'h00, 0, "rd_lo", rv, ev);     check("carry_lo", {32'b0, rv}, 64'd0);
        bus(0, 5'h04, 0, "rd_hi", rv, ev);     check("carry_hi", {32'b0, rv}, 64'd1);

        // Atomic read: the carry lands between the LO and HI reads.
        bus(1, 5'h04, 0, "wr_hi", rv, ev);
        bus(1, 5'h00, 32'hFFFF_FFFF, "wr_lo", rv, ev);
        bus(1, 5'h14, 32'h0000_0301, "ctrl_div3", rv, ev);
        bus(0, 5'h00, 0, "atomic_lo", rv, ev); check("atomic_lo", {32'b0, rv}, 64'hFFFF_FFFF);
        idle(2);
        bus(0, 5'h04, 0, "atomic_hi", rv, ev); check("atomic_hi_shadow", {32'b0, rv}, 64'd0);
        bus(1, 5'h14, 0, "ctrl_off", rv, ev);

        // Compare: irq rises after mtime reaches 0x20, falls after CMP moves away.
        bus(1, 5'h00, 0, "wr_lo", rv, ev);
        bus(1, 5'h04, 0, "wr_hi", rv, ev);
        bus(1, 5'h0C, 0, "wr_cmphi", rv, ev);
        bus(1, 5'h08, 32'h20, "wr_cmplo", rv, ev);
        check("irq_before", {63'b0, timer_irq}, 64'd0);
        bus(1, 5'h14, 32'h1, "ctrl_div0", rv, ev);
        idle(40);
        check("irq_high", {63'b0, timer_irq}, 64'd1);
        bus(1, 5'h08, 32'h1000, "wr_cmplo", rv, ev);
        check("irq_fall", {63'b0, timer_irq}, 64'd0);

        // MTIME_LO write on a tick edge: write wins, tick is dropped.
        bus(1, 5'h14, 32'h0000_0201, "ctrl_div2", rv, ev);
        idle(1);
        bus(1, 5'h00, 32'h5, "wr_lo_tick", rv, ev);
        bus(1, 5'h14, 0, "ctrl_off", rv, ev);
        bus(0, 5'h00, 0, "rd_lo", rv, ev);     check("write_wins", {32'b0, rv}, 64'd5);

        bus(1, 5'h10, 32'hFFFF_FFFF, "wr_msip", rv, ev);
        check("sw_irq_set", {63'b0, sw_irq}, 64'd1);
        bus(0, 5'h10, 0, "rd_msip", rv, ev);   check("msip_bit0", {32'b0, rv}, 64'd1);
        bus(1, 5'h10, 0, "clr_msip", rv, ev);

        bus(0, 5'h18, 0, "rd_bad", rv, ev);
        check("bad_rd_err", {63'b0, ev}, 64'd1);
        check("bad_rd_data", {32'b0, rv}, 64'd0);
        bus(1, 5'h18, 32'hDEAD_BEEF, "wr_bad", rv, ev);
        check("bad_wr_err", {63'b0, ev}, 64'd1);

        // Reset in the ack cycle drops the transfer.
        req = 1'b1; we = 1'b0; addr = 5'h00;
        cycle();
        rst_n = 1'b0; model_reset(); #1;
        check("reset_mid_ack", {63'b0, ack}, 64'd0);
        req = 1'b0;
        cycle();
        check("reset_held_ack", {63'b0, ack}, 64'd0);
        rst_n = 1'b1;
        cycle();

        for (int i = 0; i < 300; i++) begin
            logic [4:0]  a;
            logic [31:0] d;
            bit          w;
            a = rnd_addr[$urandom_range(0, 8)];
            w = $urandom_range(0, 1) == 1;
            d = $urandom;
            if (a == 5'h14) d = {16'b0, 8'($urandom_range(0, 3)), 7'b0, 1'($urandom_range(0, 1))};
            if (a == 5'h04 || a == 5'h0C) d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 1));
            bus(w, a, d, "rnd", rv, ev);
            idle($urandom_range(0, 3));
        end
        bus(0, 5'h00, 0, "final_lo", rv, ev);
        bus(0, 5'h04, 0, "final_hi", rv, ev);
        bus(0, 5'h14, 0, "final_ctrl", rv, ev);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
